operand_pair_fifo: RTL
======================

// Module: operand_pair_fifo
// PURPOSE
//   Upstream operand stage for the pipelined modular subtractor. It holds one independent FIFO per
//   operand channel, so the two operand producers can run out of step. The downstream subtractor
//   only consumes when both channels are valid, and this block decouples the producers from that.
//   Its master side has the same per-channel valid/data/ready bundle the subtractor's sink expects.
//   Each accepted operand is also range-checked against the modulus P.
// PARAMETERS
//   P              100  modulus; operands are expected to satisfy 0 <= x < P
//   BITS           $clog2(P)  significant operand bits stored and forwarded
//   C_DATA_WIDTH   32   per-channel data width on both sides (>= BITS)
//   C_NUM_CHANNELS 2    number of independent operand channels
//   DEPTH          4    entries per channel FIFO; power of two, >= 2
// PORTS
//   aclk      in   1                         clock; all logic is on the rising edge
//   aresetn   in   1                         synchronous, active-low reset
//   s_tvalid  in   [C_NUM_CHANNELS]          per-channel producer valid
//   s_tdata   in   [C_NUM_CHANNELS][C_DATA_WIDTH]  per-channel producer operand
//   s_tready  out  [C_NUM_CHANNELS]          per-channel accept; high = that FIFO is not full
//   m_tvalid  out  [C_NUM_CHANNELS]          per-channel output valid; high = that FIFO is not empty
//   m_tdata   out  [C_NUM_CHANNELS][C_DATA_WIDTH]  head entry, zero-extended above BITS
//   m_tready  in   [C_NUM_CHANNELS]          per-channel consumer ready
//   level     out  [C_NUM_CHANNELS][$clog2(DEPTH)+1]  per-channel occupancy, 0..DEPTH
//   range_err out  [C_NUM_CHANNELS]          sticky: an accepted operand on that channel was >= P
// BEHAVIOUR
//   - Reset (aresetn=0 at a rising edge) clears all pointers, counts and range_err.
//     After that edge: s_tready=all 1, m_tvalid=0, level=0, range_err=0. Storage contents are
//     don't-care, but m_tdata must read as 0 while m_tvalid=0.
//   - Reset mid-operation discards all queued entries on every channel in the same edge.
//     No partial pop or push completes in that cycle.
//   - Push on channel c: s_tvalid[c] && s_tready[c]. Store s_tdata[c][BITS-1:0] at wr_ptr[c];
//     wr_ptr[c]++.
//   - Pop on channel c: m_tvalid[c] && m_tready[c]. rd_ptr[c]++.
//   - Channels are fully independent. A push or pop on one channel never affects another.
//   - s_tready[c] = (count[c] != DEPTH). It is registered-state derived and has no comb path
//     from m_tready. When full, a same-cycle pop does NOT admit a push (no bypass).
//   - m_tvalid[c] = (count[c] != 0). m_tdata[c] is a combinational read of the entry at rd_ptr[c].
//   - Latency: a word pushed at edge N gives m_tvalid=1 after edge N, so it can be consumed in
//     cycle N+1. There is no empty-to-output bypass.
//   - Simultaneous push and pop on the same channel (0 < count < DEPTH): count is unchanged and
//     both pointers advance.
//   - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is held separately,
//     $clog2(DEPTH)+1 bits; level = count.
//   - Ordering: strict FIFO per channel. No reordering or duplication; no loss except on reset.
//   - m_tvalid/m_tdata stay stable while m_tvalid && !m_tready (AXI-stream rule).
//   - Range check: on a push, if s_tdata[c][BITS-1:0] >= P, set range_err[c] to 1 at that edge.
//     The word is still stored and forwarded unchanged. range_err clears only on reset.
//   - Bits of s_tdata above BITS are ignored and never stored.
// TESTING
//   1. Reset values: hold aresetn=0 for 3 cycles, release -> s_tready=2'b11, m_tvalid=2'b00,
//      level={0,0}, range_err=2'b00.
//   2. Fill/full: DEPTH=4, push 5,6,7,8 on ch0 with m_tready=0 -> level[0]=4, s_tready[0]=0.
//      A 5th word (9) is not accepted. ch1 still shows s_tready=1.
//   3. Full + pop: at level 4, assert m_tready[0] and s_tvalid[0] together -> 5 is popped, no push
//      that cycle, level=3, s_tready[0]=1 on the next cycle.
//   4. Wrap/order: stream 10 words (1..10) on ch1 against random m_tready -> output order is
//      exactly 1..10. level never exceeds 4. Simultaneous push/pop at level 2 keeps level 2.
//   5. Range: P=100, push 99 then 100 on ch0 -> range_err[0] is 0 after 99 and 1 after 100.
//      Both 99 and 100 appear on m_tdata. range_err[1] stays 0.
//   6. Reset mid-run: ch0 level=3, ch1 level=1, pull aresetn low for one edge -> both levels 0,
//      m_tvalid=0, range_err cleared, and subsequent pushes start fresh.

Source files
------------

// File: rtl/operand_pair_fifo.sv
// operand_pair_fifo: independent per-channel operand FIFOs with sticky range check against modulus P
module operand_pair_fifo #(
  parameter int P = 100,
  parameter int BITS = $clog2(P),
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [C_NUM_CHANNELS-1:0]              s_tvalid,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] s_tdata,
  output logic [C_NUM_CHANNELS-1:0]              s_tready,
  output logic [C_NUM_CHANNELS-1:0]              m_tvalid,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] m_tdata,
  input  logic [C_NUM_CHANNELS-1:0]              m_tready,
  output logic [C_NUM_CHANNELS*(AW+1)-1:0]       level,
  output logic [C_NUM_CHANNELS-1:0]              range_err
);
  localparam logic [BITS:0] PW = (BITS+1)'(P);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [C_DATA_WIDTH-1:0] din_unused;
    logic push, pop;
    assign din_unused = s_tdata[c*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign s_tready[c] = count != FULL;
    assign m_tvalid[c] = count != '0;
    assign push = s_tvalid[c] && s_tready[c];
    assign pop = m_tvalid[c] && m_tready[c];
    assign level[c*(AW+1) +: AW+1] = count;
    assign m_tdata[c*C_DATA_WIDTH +: C_DATA_WIDTH] = m_tvalid[c] ? C_DATA_WIDTH'(mem[rd_ptr]) : '0;
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        range_err[c] <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= din_unused[BITS-1:0];
          wr_ptr <= wr_ptr + AW'(1);
          if ({1'b0, din_unused[BITS-1:0]} >= PW) range_err[c] <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule
